clk_div_prog: RTL and testbench

Runtime-programmable integer clock divider producing a 50 %-duty output for both even and odd ratios. The division ratio can be changed glitch-free at output-period boundaries, and the output can be started and stopped cleanly. It supersedes the fixed divide-by-N blocks and feeds derived clocks to slow peripherals and test outputs.

---
 rtl/clk_div_pkg.sv | 16 +
 rtl/clk_div_ratio_ctrl.sv | 56 +++++
 rtl/clk_div_prog.sv | 118 +++++++++++
 tb/tb_clk_div_prog.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared definitions for the programmable clock divider.
package clk_div_pkg;

    // Smallest ratio that still yields a high and a low phase.
    localparam int MIN_DIV = 2;

    // Default width of the ratio field.
    localparam int DEFAULT_DIV_W = 8;

    // Divider run state.
    typedef enum logic {
        STOP = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/clk_div_ratio_ctrl.sv
// Ratio bookkeeping: legality check, pending register, apply/ack/err and the
// ratio currently in force.
module clk_div_ratio_ctrl
    import clk_div_pkg::*;
#(
    parameter int DIV_W       = DEFAULT_DIV_W,
    parameter int DEFAULT_DIV = 6
)(
    input  logic             clk,
    input  logic             rstn,
    input  logic [DIV_W-1:0] div_ratio,
    input  logic             div_load,
    input  logic             apply,
    output logic [DIV_W-1:0] div_active,
    output logic             load_ack,
    output logic             load_err
);

    logic [DIV_W-1:0] pending_reg;
    logic             pending_valid_reg;
    logic [DIV_W-1:0] active_reg;
    logic             ack_reg;
    logic             err_reg;
    logic             ratio_legal;

    assign ratio_legal = (div_ratio >= DIV_W'(MIN_DIV));

    // Apply uses the pending value from before this edge, so a load arriving
    // on an apply edge is held for the next boundary (last load wins).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pending_reg       <= '0;
            pending_valid_reg <= 1'b0;
            active_reg        <= DIV_W'(DEFAULT_DIV);
            ack_reg           <= 1'b0;
            err_reg           <= 1'b0;
        end else begin
            ack_reg <= 1'b0;
            err_reg <= div_load && !ratio_legal;
            if (apply && pending_valid_reg) begin
                active_reg        <= pending_reg;
                ack_reg           <= 1'b1;
                pending_valid_reg <= 1'b0;
            end
            if (div_load && ratio_legal) begin
                pending_reg       <= div_ratio;
                pending_valid_reg <= 1'b1;
            end
        end
    end

    assign div_active = active_reg;
    assign load_ack   = ack_reg;
    assign load_err   = err_reg;

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable 50%-duty integer clock divider with clean start/stop.
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int DIV_W       = DEFAULT_DIV_W,
    parameter int DEFAULT_DIV = 6
)(
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic [DIV_W-1:0] div_ratio,
    input  logic             div_load,
    output logic             load_ack,
    output logic             load_err,
    output logic [DIV_W-1:0] div_active,
    output logic             tick,
    output logic             clk_out
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    state_t           state_reg, state_next;
    logic [DIV_W-1:0] cnt_reg, cnt_next;
    logic [DIV_W-1:0] cnt_inc;
    logic [DIV_W-1:0] half_period;
    logic             p_reg, p_next;
    logic             n_reg;
    logic             tick_reg, tick_next;
    logic             period_end;
    logic             apply;

    assign cnt_inc     = cnt_reg + ONE;
    assign half_period = div_active >> 1;
    assign period_end  = (state_reg == RUN) && (cnt_reg == (div_active - ONE));
    // New ratios land only where the output is low and a period restarts.
    assign apply       = (state_reg == STOP) || period_end;

    clk_div_ratio_ctrl #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ratio_ctrl (
        .clk        (clk),
        .rstn       (rstn),
        .div_ratio  (div_ratio),
        .div_load   (div_load),
        .apply      (apply),
        .div_active (div_active),
        .load_ack   (load_ack),
        .load_err   (load_err)
    );

    // State, counter, posedge phase flop and tick register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= STOP;
            cnt_reg   <= '0;
            p_reg     <= 1'b0;
            tick_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            p_reg     <= p_next;
            tick_reg  <= tick_next;
        end
    end

    // Next-state: periods always run to completion before stopping.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        p_next     = p_reg;
        tick_next  = 1'b0;
        case (state_reg)
            STOP: begin
                if (en) begin
                    state_next = RUN;
                    cnt_next   = '0;
                    p_next     = 1'b1;
                    tick_next  = 1'b1;
                end
            end
            RUN: begin
                if (period_end) begin
                    cnt_next = '0;
                    if (en) begin
                        p_next    = 1'b1;
                        tick_next = 1'b1;
                    end else begin
                        state_next = STOP;
                        p_next     = 1'b0;
                    end
                end else begin
                    cnt_next = cnt_inc;
                    p_next   = (cnt_inc < half_period);
                end
            end
            default: begin
                state_next = STOP;
                cnt_next   = '0;
                p_next     = 1'b0;
            end
        endcase
    end

    // Negedge copy of p; stretches the high phase by half a cycle for odd N.
    always_ff @(negedge clk or negedge rstn) begin
        if (!rstn) begin
            n_reg <= 1'b0;
        end else begin
            n_reg <= p_reg;
        end
    end

    // Output select comes from the registered ratio LSB, not the counter.
    assign clk_out = div_active[0] ? (p_reg | n_reg) : p_reg;
    assign tick    = tick_reg;

endmodule

// File: tb/tb_clk_div_prog.sv
// Scoreboard bench for clk_div_prog: stimulus queues expected periods,
// acks and errors; a monitor sampling both clock edges pops and compares.
module tb_clk_div_prog;

    localparam int DIV_W = 8;

    typedef struct {
        int gap;   // cycles between ticks, -1 when a stop intervened
        int high;  // half-cycles of clk_out high since previous tick
    } period_t;

    logic             clk;
    logic             rstn;
    logic             en;
    logic [DIV_W-1:0] div_ratio;
    logic             div_load;
    logic             load_ack;
    logic             load_err;
    logic [DIV_W-1:0] div_active;
    logic             tick;
    logic             clk_out;

    int checks = 0;
    int errors = 0;

    period_t exp_tick_q[$];
    int      exp_ack_q[$];
    int      exp_err_q[$];

    clk_div_prog #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (6)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .en         (en),
        .div_ratio  (div_ratio),
        .div_load   (div_load),
        .load_ack   (load_ack),
        .load_err   (load_err),
        .div_active (div_active),
        .tick       (tick),
        .clk_out    (clk_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push_period(input int gap, input int high);
        period_t e;
        e.gap  = gap;
        e.high = high;
        exp_tick_q.push_back(e);
    endtask

    task automatic do_load(input int r);
        @(negedge clk);
        div_load  = 1'b1;
        div_ratio = DIV_W'(r);
        @(negedge clk);
        div_load  = 1'b0;
    endtask

    task automatic wait_tick();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (tick) begin
                seen = 1'b1;
                break;
            end
        end
        check("tick_timeout", int'(seen), 1);
    endtask

    // Monitor: one sample per half cycle, 1 time unit after each edge.
    initial begin
        int      half_cnt;
        int      high_halves;
        bit      have_prev;
        period_t e;
        int      v;
        half_cnt    = 0;
        high_halves = 0;
        have_prev   = 1'b0;
        forever begin
            @(clk);
            #1;
            if (!rstn) begin
                have_prev   = 1'b0;
                half_cnt    = 0;
                high_halves = 0;
            end else begin
                if (clk) begin
                    if (tick) begin
                        if (have_prev) begin
                            if (exp_tick_q.size() == 0) begin
                                check("unexpected_tick", 1, 0);
                            end else begin
                                e = exp_tick_q.pop_front();
                                $display("tick: gap=%0d high_halves=%0d (exp gap=%0d high=%0d)",
                                         half_cnt / 2, high_halves, e.gap, e.high);
                                if (e.gap >= 0) check("period_gap", half_cnt / 2, e.gap);
                                check("high_halves", high_halves, e.high);
                            end
                        end
                        check("tick_with_rise", int'(clk_out), 1);
                        have_prev   = 1'b1;
                        half_cnt    = 0;
                        high_halves = 0;
                    end
                    if (load_ack) begin
                        if (exp_ack_q.size() == 0) begin
                            check("unexpected_ack", 1, 0);
                        end else begin
                            v = exp_ack_q.pop_front();
                            $display("ack: div_active=%0d (exp %0d)", div_active, v);
                            check("ack_div_active", int'(div_active), v);
                        end
                    end
                    if (load_err) begin
                        if (exp_err_q.size() == 0) begin
                            check("unexpected_err", 1, 0);
                        end else begin
                            v = exp_err_q.pop_front();
                            $display("err: div_active=%0d (exp %0d)", div_active, v);
                            check("err_div_active", int'(div_active), v);
                        end
                    end
                end
                half_cnt++;
                if (clk_out) high_halves++;
            end
        end
    end

    // Stimulus
    initial begin
        rstn      = 1'b0;
        en        = 1'b0;
        div_load  = 1'b0;
        div_ratio = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_clk_out", int'(clk_out), 0);
        check("rst_tick", int'(tick), 0);
        check("rst_load_ack", int'(load_ack), 0);
        check("rst_load_err", int'(load_err), 0);
        check("rst_div_active", int'(div_active), 6);
        rstn = 1'b1;

        // Ratio 6: first rise on the first enabled edge, then 3/3 periods
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
        check("first_rise_clk_out", int'(clk_out), 1);
        check("first_rise_tick", int'(tick), 1);
        push_period(6, 6);
        push_period(6, 6);
        wait_tick();
        wait_tick();

        // Load 5 mid-period: current 6-period completes, then 2.5/2.5
        exp_ack_q.push_back(5);
        push_period(6, 6);
        do_load(5);
        wait_tick();
        push_period(5, 5);
        push_period(5, 5);
        wait_tick();
        wait_tick();

        // Load 7 then 9 in one period: only 9 applies, single ack
        exp_ack_q.push_back(9);
        push_period(5, 5);
        do_load(7);
        do_load(9);
        wait_tick();
        push_period(9, 9);
        wait_tick();

        // Illegal loads 1 and 0: two errors, ratio unchanged
        exp_err_q.push_back(9);
        exp_err_q.push_back(9);
        push_period(9, 9);
        do_load(1);
        do_load(0);
        wait_tick();
        check("after_err_div_active", int'(div_active), 9);

        // Ratio 4, then drop en at cnt=1
        exp_ack_q.push_back(4);
        push_period(9, 9);
        do_load(4);
        wait_tick();
        push_period(4, 4);
        wait_tick();
        @(negedge clk);
        @(negedge clk);
        en = 1'b0;
        repeat (6) @(negedge clk);
        check("stopped_clk_out", int'(clk_out), 0);
        check("stopped_div_active", int'(div_active), 4);
        repeat (3) @(negedge clk);
        check("stopped_clk_out_late", int'(clk_out), 0);
        push_period(-1, 4);
        en = 1'b1;
        wait_tick();
        push_period(4, 4);
        wait_tick();

        // Reset during high phase with a load of 8 pending
        do_load(8);
        check("pre_reset_clk_out", int'(clk_out), 1);
        #2;
        rstn = 1'b0;
        #1;
        check("reset_clk_out", int'(clk_out), 0);
        check("reset_div_active", int'(div_active), 6);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        wait_tick();
        check("post_reset_div_active", int'(div_active), 6);
        push_period(6, 6);
        wait_tick();
        check("post_reset_div_active_late", int'(div_active), 6);

        repeat (3) @(negedge clk);
        check("tick_queue_empty", exp_tick_q.size(), 0);
        check("ack_queue_empty", exp_ack_q.size(), 0);
        check("err_queue_empty", exp_err_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
